// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth partial-product accumulator.
// Ports: none (package only).
// Widths: 34-bit partial products, 64-bit product; up to 17 partial products per operation.
package booth_pkg;

   localparam int PP_W         = 34;
   localparam int PROD_W       = 64;
   localparam int NPP_UNSIGNED = 17;
   localparam int NPP_SIGNED   = 16;
   localparam int IDX_W        = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth_pp_align.sv
// Aligns one radix-4 Booth partial product to its weight: term = (sext64(pp_data) + pp_neg) << 2*idx.
// Latency: purely combinational. Backpressure: none.
// Ports: pp_data/pp_neg (raw partial product and negate bit), idx (digit position), term (aligned 64-bit value).
module booth_pp_align
   import booth_pkg::*;
(
   input  logic [PP_W-1:0]   pp_data,
   input  logic              pp_neg,
   input  logic [IDX_W-1:0]  idx,
   output logic [PROD_W-1:0] term
);

   logic [PROD_W-1:0] pp_ext;
   logic [PROD_W-1:0] neg_ext;
   logic [5:0]        shamt;

   always_comb begin
      pp_ext  = {{(PROD_W-PP_W){pp_data[PP_W-1]}}, pp_data};
      neg_ext = {{(PROD_W-1){1'b0}}, pp_neg};
      // Radix-4 digit i carries weight 4^i.
      shamt   = {idx, 1'b0};
      // The +1 of the two's-complement negation is added at the same weight as the digit.
      term    = (pp_ext << shamt) + (neg_ext << shamt);
   end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Accumulates 16 (signed) or 17 (unsigned) radix-4 Booth partial products into a 64-bit product.
// Latency: product valid the cycle after the last pp handshake; held in DONE until prod handshake.
// Backpressure: pp_ready=0 while a product waits, so a new operation starts only after the prod handshake.
// Ports: clk, rst_n (async active-low); pp_valid/pp_ready/pp_data/pp_neg/pp_sign (partial-product input);
//        prod_valid/prod_ready/prod_data (product output); flush (only when BOOTH_ACC_FLUSH_EN is defined).
module booth_pp_accumulator
   import booth_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
`ifdef BOOTH_ACC_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              pp_valid,
   output logic              pp_ready,
   input  logic [PP_W-1:0]   pp_data,
   input  logic              pp_neg,
   input  logic              pp_sign,
   output logic              prod_valid,
   input  logic              prod_ready,
   output logic [PROD_W-1:0] prod_data
);

   state_t            state;
   logic [PROD_W-1:0] acc;
   logic [IDX_W-1:0]  idx;
   logic              sign_q;

   logic              flush_act;
   logic              pp_hs;
   logic              prod_hs;
   logic              op_sign;
   logic [IDX_W-1:0]  cur_idx;
   logic [IDX_W-1:0]  last_idx;
   logic              last_pp;
   logic [PROD_W-1:0] term;

`ifdef BOOTH_ACC_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   assign pp_ready   = (state != ST_DONE) && !flush_act;
   assign prod_valid = (state == ST_DONE);
   // acc is frozen in DONE, so it can drive the product directly.
   assign prod_data  = acc;

   assign pp_hs   = pp_valid && pp_ready;
   assign prod_hs = prod_valid && prod_ready;

   // The first partial product uses the live pp_sign; later ones use the latched copy.
   assign op_sign  = (state == ST_IDLE) ? pp_sign : sign_q;
   assign cur_idx  = (state == ST_IDLE) ? '0 : idx;
   assign last_idx = op_sign ? IDX_W'(NPP_SIGNED - 1) : IDX_W'(NPP_UNSIGNED - 1);
   assign last_pp  = (cur_idx == last_idx);

   booth_pp_align u_align (
      .pp_data (pp_data),
      .pp_neg  (pp_neg),
      .idx     (cur_idx),
      .term    (term)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         acc    <= '0;
         idx    <= '0;
         sign_q <= 1'b0;
      end else if (flush_act) begin
         state <= ST_IDLE;
         acc   <= '0;
         idx   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // At least 16 products per operation, so index 0 is never the last one.
               if (pp_hs) begin
                  sign_q <= pp_sign;
                  acc    <= term;
                  idx    <= IDX_W'(1);
                  state  <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (pp_hs) begin
                  acc <= acc + term;
                  if (last_pp) begin
                     // idx stays put so it never exceeds 16.
                     state <= ST_DONE;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (prod_hs) begin
                  state <= ST_IDLE;
                  idx   <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized self-checking bench for booth_pp_accumulator.
// Partial products come from a radix-4 Booth recoding of A and B; the expected product is A*B.
// Build with BOOTH_ACC_FLUSH_EN defined to also exercise the flush port.
module tb_booth_pp_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pp_valid;
   logic        pp_ready;
   logic [33:0] pp_data;
   logic        pp_neg;
   logic        pp_sign;
   logic        prod_valid;
   logic        prod_ready;
   logic [63:0] prod_data;
`ifdef BOOTH_ACC_FLUSH_EN
   logic        flush;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [33:0] q_dat[$];
   logic        q_neg[$];

   always #5 clk = ~clk;

   booth_pp_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef BOOTH_ACC_FLUSH_EN
      .flush      (flush),
`endif
      .pp_valid   (pp_valid),
      .pp_ready   (pp_ready),
      .pp_data    (pp_data),
      .pp_neg     (pp_neg),
      .pp_sign    (pp_sign),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_data  (prod_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Radix-4 Booth recoding: digit i = -2*b[2i+1] + b[2i] + b[2i-1]; pp = digit*A,
   // negative digits sent as the one's complement plus the negate bit.
   task automatic build_pps(input logic [31:0] a, input logic [31:0] b, input logic sgn, output int n);
      logic [35:0] aext;
      logic [34:0] bext;
      logic [35:0] m;
      logic [2:0]  trip;
      int          d;
      int          dm;
      q_dat.delete();
      q_neg.delete();
      aext = sgn ? {{4{a[31]}}, a} : {4'b0, a};
      bext = sgn ? {{2{b[31]}}, b, 1'b0} : {2'b0, b, 1'b0};
      n = sgn ? 16 : 17;
      for (int i = 0; i < n; i++) begin
         trip = bext[2*i+2 -: 3];
         d  = -2 * int'(trip[2]) + int'(trip[1]) + int'(trip[0]);
         dm = (d < 0) ? -d : d;
         m  = (dm == 2) ? (aext << 1) : ((dm == 1) ? aext : 36'd0);
         if (d < 0) begin
            q_dat.push_back(~m[33:0]);
            q_neg.push_back(1'b1);
         end else begin
            q_dat.push_back(m[33:0]);
            q_neg.push_back(1'b0);
         end
      end
   endtask

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic [63:0] xa;
      logic [63:0] xb;
      xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
      xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
      return xa * xb;
   endfunction

   // gap: 0 = back-to-back, 1 = idle cycle between products, 2 = random idle cycles.
   // stop_after > 0 abandons the operation after that many accepted partial products.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int gap, input int stall, input int stop_after);
      int          n;
      int          w;
      logic [63:0] exp;
      build_pps(a, b, sgn, n);
      exp = ref_prod(a, b, sgn);
      for (int i = 0; i < n; i++) begin
         if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0))) begin
            pp_valid = 1'b0;
            pp_data  = {2'($urandom), 32'($urandom)};
            pp_neg   = 1'($urandom_range(0, 1));
            pp_sign  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         pp_valid = 1'b1;
         pp_data  = q_dat[i];
         pp_neg   = q_neg[i];
         pp_sign  = (i == 0) ? sgn : 1'($urandom_range(0, 1));
         #1;
         if (i == 0) chk("first_pp_ready", 64'(pp_ready), 64'd1);
         w = 0;
         while (!pp_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
         end
         if (w >= 40) begin
            chk("pp_ready_timeout", 64'(pp_ready), 64'd1);
            pp_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
         chk("prod_valid_after_pp", 64'(prod_valid), 64'(i == n - 1));
         if (stop_after > 0 && i + 1 == stop_after) begin
            pp_valid = 1'b0;
            return;
         end
      end
      // Keep offering junk while the product waits; none of it may be taken.
      pp_valid = 1'b1;
      pp_data  = {2'($urandom), 32'($urandom)};
      pp_sign  = 1'($urandom_range(0, 1));
      chk("prod_data", prod_data, exp);
      chk("pp_ready_done", 64'(pp_ready), 64'd0);
      prod_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk("stall_prod_data", prod_data, exp);
         chk("stall_prod_valid", 64'(prod_valid), 64'd1);
         chk("stall_pp_ready", 64'(pp_ready), 64'd0);
      end
      prod_ready = 1'b1;
      @(posedge clk); #1;
      prod_ready = 1'b0;
      pp_valid   = 1'b0;
      chk("idle_prod_valid", 64'(prod_valid), 64'd0);
      chk("idle_pp_ready", 64'(pp_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      pp_valid   = 1'b0;
      pp_data    = '0;
      pp_neg     = 1'b0;
      pp_sign    = 1'b0;
      prod_ready = 1'b0;
`ifdef BOOTH_ACC_FLUSH_EN
      flush      = 1'b0;
`endif
      #12;
      chk("rst_pp_ready", 64'(pp_ready), 64'd1);
      chk("rst_prod_valid", 64'(prod_valid), 64'd0);
      chk("rst_prod_data", prod_data, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
      run_op(32'h8000_0000, 32'h0000_0002, 1'b1, 1, 0, 0);
      run_op($urandom, $urandom, 1'b0, 0, 5, 0);
      run_op($urandom, $urandom, 1'b1, 0, 0, 0);

      // Reset in the middle of an operation.
      run_op($urandom, $urandom, 1'b0, 0, 0, 7);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_pp_ready", 64'(pp_ready), 64'd1);
      chk("midrst_prod_valid", 64'(prod_valid), 64'd0);
      chk("midrst_prod_data", prod_data, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(32'd3, 32'd5, 1'b0, 0, 0, 0);

`ifdef BOOTH_ACC_FLUSH_EN
      // Flush together with the 10th partial product.
      run_op($urandom, $urandom, 1'b1, 0, 0, 9);
      pp_valid = 1'b1;
      pp_data  = q_dat[9];
      pp_neg   = q_neg[9];
      flush    = 1'b1;
      #1;
      chk("flush_pp_ready", 64'(pp_ready), 64'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      pp_valid = 1'b0;
      chk("flush_prod_valid", 64'(prod_valid), 64'd0);
      run_op(32'd7, 32'd9, 1'b0, 0, 0, 0);
`endif

      // Random operations with random gaps and stalls.
      for (int k = 0; k < 25; k++) begin
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 2, $urandom_range(0, 3), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/booth_pp_accumulator.md
BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pp_valid, input, 1 bit: a partial product is offered.
REQ-004 SHALL have port pp_ready, output, 1 bit: the block accepts the offered partial product.
REQ-005 SHALL have port pp_data, input, 34 bits: radix-4 Booth partial product, two's complement, bit 33 is the sign.
REQ-006 SHALL have port pp_neg, input, 1 bit: the negate bit of the Booth triplet, which requires a +1 correction.
REQ-007 SHALL have port pp_sign, input, 1 bit: 1 = signed operation, 0 = unsigned; sampled only on the first partial product of an operation.
REQ-008 SHALL have port prod_valid, output, 1 bit: the product is available.
REQ-009 SHALL have port prod_ready, input, 1 bit: the consumer accepts the product.
REQ-010 SHALL have port prod_data, output, 64 bits: the accumulated product.

Function
REQ-011 SHALL define a handshake as a cycle with valid=1 and ready=1 on the respective interface.
REQ-012 SHALL implement the FSM IDLE -> ACC -> DONE -> IDLE.
REQ-013 SHALL assert pp_ready=1 in IDLE and ACC, and pp_ready=0 in DONE.
REQ-014 SHALL, on a pp handshake in IDLE: latch pp_sign into sign_q, set idx=1, set acc = term(0), and go to ACC.
REQ-015 SHALL, on a pp handshake in ACC: set acc = acc + term(idx) and increment idx.
- Definition of term(i): sext64(pp_data) << 2i, plus (pp_neg << 2i), computed mod 2^64.
REQ-016 SHALL set the number of partial products per operation N to 17 when sign_q=0 and 16 when sign_q=1.
REQ-017 SHALL, on the handshake of partial product index N-1, go to DONE, with prod_valid=1 in the next cycle (1 cycle latency after the last pp handshake).
REQ-018 SHALL hold prod_data stable while in DONE, and go to IDLE on a prod handshake.
REQ-019 SHALL drive prod_valid=0 outside DONE; prod_data is don't-care outside DONE.
REQ-020 SHALL keep acc and idx unchanged in any cycle with pp_valid=0.
REQ-021 SHALL ignore pp_sign after the first partial product of an operation.
REQ-022 SHALL hold idx in the range 0..16 with no wrap; idx is cleared on entry to IDLE.
REQ-023 SHALL NOT allow overlap: a new operation's first partial product is accepted only in the cycle after a prod handshake.

Reset
REQ-024 SHALL, while rst_n=0: force state=IDLE, acc=0, idx=0, sign_q=0, pp_ready=1, prod_valid=0, prod_data=0.
REQ-025 SHALL, on reset assertion mid-operation, discard the partial sum; the next accepted partial product starts a new operation.

Configuration
REQ-026 SHALL support macro BOOTH_ACC_FLUSH_EN.
REQ-027 SHALL, when BOOTH_ACC_FLUSH_EN is defined, add input port flush (1 bit) that synchronously returns the FSM to IDLE with acc=0 and idx=0. Flush has priority over any handshake in the same cycle, and pp_ready=0 during the flush cycle.
REQ-028 SHALL, when BOOTH_ACC_FLUSH_EN is undefined, omit the flush port and flush logic; behaviour is otherwise identical.

Structure
REQ-029 SHALL place in package booth_pkg: constants PP_W=34, PROD_W=64, NPP_UNSIGNED=17, NPP_SIGNED=16, and the FSM state enum type.
REQ-030 SHALL implement term(i) in one combinational sub-module, booth_pp_align, covering sign extension, 2i shift and negate-bit injection.

Verification
REQ-031 SHALL cover: unsigned A=0xFFFFFFFF, B=0xFFFFFFFF, 17 partial products from the model, no stalls -> prod_data=0xFFFFFFFE00000001 one cycle after the 17th handshake.
REQ-032 SHALL cover: signed A=0xFFFFFFFF, B=0xFFFFFFFF (-1 x -1), 16 partial products -> prod_data=0x0000000000000001, prod_valid at cycle 17.
REQ-033 SHALL cover: signed A=0x80000000, B=0x00000002, pp_valid toggled every other cycle -> prod_data=0xFFFFFFFF00000000; acc unchanged in idle gaps.
REQ-034 SHALL cover: product stalled (prod_ready=0 for 5 cycles) -> prod_data stable, pp_ready=0 throughout, pp_valid=1 not consumed; the next operation is accepted the cycle after the prod handshake.
REQ-035 SHALL cover: rst_n pulsed low after the 7th partial product -> outputs at reset values; a following unsigned 3x5 -> prod_data=0x000000000000000F.
REQ-036 SHALL cover (BOOTH_ACC_FLUSH_EN): flush asserted together with the 10th pp_valid -> that partial product is not accepted; a following unsigned 7x9 -> prod_data=0x000000000000003F.
